// File: rtl/imu_pkg.sv
// Shared definitions for the IMU axis sequencer: axis codes, FSM state encoding,
// default sample width and the next-enabled-axis helper.
package imu_pkg;

   localparam int unsigned WIDTH_DEF = 16;

   localparam logic [1:0] AXIS_X = 2'd0;
   localparam logic [1:0] AXIS_Y = 2'd1;
   localparam logic [1:0] AXIS_Z = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND_X = 2'd1,
      ST_SEND_Y = 2'd2,
      ST_SEND_Z = 2'd3
   } state_e;

   // Lowest enabled axis at or above index 'from' (state code n+1 serves axis n), else IDLE.
   function automatic state_e first_from(input logic [2:0] mask, input logic [1:0] from);
      state_e s;
      s = ST_IDLE;
      if ((from <= 2'd2) && mask[2]) s = ST_SEND_Z;
      if ((from <= 2'd1) && mask[1]) s = ST_SEND_Y;
      if ((from == 2'd0) && mask[0]) s = ST_SEND_X;
      return s;
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample divider: one-cycle tick every SAMPLE_DIV clocks while enabled,
// counter parked at zero while disabled.
module sample_tick_gen #(
   parameter int unsigned SAMPLE_DIV = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   output logic o_tick_c
);

   localparam int unsigned   CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_cnt <= '0;
      else if (!i_en || r_cnt == LAST) r_cnt <= '0;
      else                             r_cnt <= r_cnt + CW'(1);
   end

   assign o_tick_c = i_en && (r_cnt == LAST);

endmodule

// File: rtl/imu_axis_sequencer.sv
// Time-shares one downstream channel between the X/Y/Z IMU axes: snapshots a coherent
// frame on each sample tick and streams the enabled axes out over valid/ready.
module imu_axis_sequencer
   import imu_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned SAMPLE_DIV = 1000,
   parameter int unsigned OVR_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [2:0]              axis_mask,
   input  logic signed [WIDTH-1:0] ax,
   input  logic signed [WIDTH-1:0] ay,
   input  logic signed [WIDTH-1:0] az,
   output logic signed [WIDTH-1:0] out_data,
   output logic [1:0]              out_axis,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    frame_done,
   output logic                    busy,
   output logic [OVR_W-1:0]        overrun_cnt
);

   localparam logic [OVR_W-1:0] OVR_MAX = '1;

   state_e           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_snap_x, r_snap_y, r_snap_z;
   logic [WIDTH-1:0] w_snap_x_nxt, w_snap_y_nxt, w_snap_z_nxt;
   logic [2:0]       r_mask, w_mask_nxt;
   logic [OVR_W-1:0] r_ovr, w_ovr_nxt;
   logic [WIDTH-1:0] r_out_data, w_data_nxt;
   logic [1:0]       r_out_axis, w_axis_nxt;
   logic             r_out_last, w_last_nxt;
   logic             r_out_valid, r_frame_done, r_busy;
   logic             w_hs, w_done_nxt, w_tick;

   sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (en),
      .o_tick_c (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_snap_x     <= '0;
         r_snap_y     <= '0;
         r_snap_z     <= '0;
         r_mask       <= '0;
         r_ovr        <= '0;
         r_out_data   <= '0;
         r_out_axis   <= '0;
         r_out_last   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_snap_x     <= w_snap_x_nxt;
         r_snap_y     <= w_snap_y_nxt;
         r_snap_z     <= w_snap_z_nxt;
         r_mask       <= w_mask_nxt;
         r_ovr        <= w_ovr_nxt;
         r_out_data   <= w_data_nxt;
         r_out_axis   <= w_axis_nxt;
         r_out_last   <= w_last_nxt;
         r_out_valid  <= (w_state_nxt != ST_IDLE);
         r_frame_done <= w_done_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_snap_x_nxt = r_snap_x;
      w_snap_y_nxt = r_snap_y;
      w_snap_z_nxt = r_snap_z;
      w_mask_nxt   = r_mask;
      w_ovr_nxt    = r_ovr;
      w_data_nxt   = '0;
      w_axis_nxt   = AXIS_X;
      w_last_nxt   = 1'b0;

      w_hs       = r_out_valid && out_ready;
      w_done_nxt = w_hs && r_out_last;

      if (w_hs) w_state_nxt = first_from(r_mask, 2'(r_state));

      // A tick landing on the closing handshake starts the next frame with no idle gap.
      if (w_tick) begin
         if ((r_state == ST_IDLE) || w_done_nxt) begin
            if (axis_mask != 3'b000) begin
               w_snap_x_nxt = ax;
               w_snap_y_nxt = ay;
               w_snap_z_nxt = az;
               w_mask_nxt   = axis_mask;
               w_state_nxt  = first_from(axis_mask, 2'd0);
            end
         end else if (r_ovr != OVR_MAX) begin
            w_ovr_nxt = r_ovr + OVR_W'(1);
         end
      end

      case (w_state_nxt)
         ST_SEND_X: begin w_data_nxt = w_snap_x_nxt; w_axis_nxt = AXIS_X; end
         ST_SEND_Y: begin w_data_nxt = w_snap_y_nxt; w_axis_nxt = AXIS_Y; end
         ST_SEND_Z: begin w_data_nxt = w_snap_z_nxt; w_axis_nxt = AXIS_Z; end
         default:   begin w_data_nxt = '0;           w_axis_nxt = AXIS_X; end
      endcase
      w_last_nxt = (w_state_nxt != ST_IDLE) &&
                   (first_from(w_mask_nxt, 2'(w_state_nxt)) == ST_IDLE);
   end

   assign out_data    = r_out_data;
   assign out_axis    = r_out_axis;
   assign out_last    = r_out_last;
   assign out_valid   = r_out_valid;
   assign frame_done  = r_frame_done;
   assign busy        = r_busy;
   assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_imu_axis_sequencer.sv
// Scoreboard bench for imu_axis_sequencer: expected beats are queued when a frame is
// set up and compared as the DUT hands them over.
module tb_imu_axis_sequencer;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DIV   = 8;
   localparam int unsigned OVR_W = 2;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [1:0]       axis;
      logic             last;
   } beat_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    en;
   logic [2:0]              axis_mask;
   logic signed [WIDTH-1:0] ax, ay, az;
   logic signed [WIDTH-1:0] out_data;
   logic [1:0]              out_axis;
   logic                    out_last, out_valid, out_ready, frame_done, busy;
   logic [OVR_W-1:0]        overrun_cnt;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   imu_axis_sequencer #(.WIDTH(WIDTH), .SAMPLE_DIV(DIV), .OVR_W(OVR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .axis_mask  (axis_mask),
      .ax         (ax),
      .ay         (ay),
      .az         (az),
      .out_data   (out_data),
      .out_axis   (out_axis),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .busy       (busy),
      .overrun_cnt(overrun_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model of one frame: enabled axes in X,Y,Z order, last flag on the highest one.
   task automatic push_frame(input logic [2:0] m, input logic [WIDTH-1:0] x,
                             input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
      logic [WIDTH-1:0] s[3];
      int hi;
      beat_t b;
      s[0] = x; s[1] = y; s[2] = z;
      hi = m[2] ? 2 : (m[1] ? 1 : 0);
      for (int i = 0; i < 3; i++) begin
         if (m[2'(i)]) begin
            b.data = s[i];
            b.axis = 2'(i);
            b.last = (i == hi);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic do_reset(input logic [2:0] m, input logic rdy, input logic en_v);
      rst_n     = 1'b0;
      en        = 1'b0;
      axis_mask = m;
      out_ready = rdy;
      step();
      step();
      exp_q.delete();
      en    = en_v;
      rst_n = 1'b1;
   endtask

   // Number of edges until out_valid is seen, capped at budget.
   task automatic count_to_valid(input int budget, output int n);
      n = 0;
      while (!out_valid && n < budget) begin
         step();
         n++;
      end
   endtask

   // Capture the beat handed over at the next edge; ok=0 if none within budget.
   task automatic wait_beat(input int budget, output bit ok, output beat_t b);
      int k;
      ok = 1'b0;
      b  = '0;
      k  = 0;
      while (!ok && k < budget) begin
         if (out_valid && out_ready) begin
            b  = {out_data, out_axis, out_last};
            ok = 1'b1;
         end
         step();
         k++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; axis_mask = 3'b111; out_ready = 1'b1;
      ax = 16'sd5; ay = 16'sd6; az = 16'sd7;
      step();
      step();
      n_checks++;
      if ({out_data, out_axis, out_last, out_valid, frame_done, busy, overrun_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {out_data, out_axis, out_last, out_valid, frame_done, busy, overrun_cnt});
      end
      rst_n = 1'b1;
      repeat (DIV - 1) step();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pretick valid=%b busy=%b exp 0 0", out_valid, busy);
      end
   endtask

   task automatic test_full_frame();
      int n; bit ok; beat_t got, e;
      ax = 16'sd100; ay = -16'sd200; az = 16'sd16384;
      do_reset(3'b111, 1'b1, 1'b1);
      push_frame(3'b111, ax, ay, az);
      count_to_valid(4 * DIV, n);
      n_checks++;
      if (n !== DIV) begin n_fail++; $display("FAIL t1_latency got=%0d exp=%0d", n, DIV); end
      ax = 16'sd1; ay = 16'sd2; az = 16'sd3;
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, ok, got);
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t1_beat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t1_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
      end
      n_checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || overrun_cnt !== '0) begin
         n_fail++;
         $display("FAIL t1_done done=%b busy=%b valid=%b ovr=%0d exp 1 0 0 0",
                  frame_done, busy, out_valid, overrun_cnt);
      end
      step();
      n_checks++;
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL t1_done_pulse got=%b exp=0", frame_done); end
   endtask

   task automatic test_mask_ready();
      int n; bit ok; beat_t got, e;
      ax = 16'sd7; ay = 16'sd8; az = -16'sd9;
      do_reset(3'b101, 1'b0, 1'b1);
      push_frame(3'b101, ax, ay, az);
      count_to_valid(4 * DIV, n);
      axis_mask = 3'b010;
      ax = 16'sd70; az = 16'sd90;
      step();
      n_checks++;
      if ({out_data, out_axis, out_last} !== exp_q[0]) begin
         n_fail++; $display("FAIL t2_hold_x got=%h/%0d/%0b exp=%h", out_data, out_axis, out_last, exp_q[0]);
      end
      for (int i = 0; i < 2; i++) begin
         out_ready = 1'b1;
         wait_beat(1, ok, got);
         out_ready = 1'b0;
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t2_beat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t2_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
         if (i == 0) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || {out_data, out_axis, out_last} !== exp_q[0]) begin
               n_fail++;
               $display("FAIL t2_hold_z valid=%b got=%h/%0d/%0b exp=%h", out_valid,
                        out_data, out_axis, out_last, exp_q[0]);
            end
         end
      end
      n_checks++;
      if (frame_done !== 1'b1) begin n_fail++; $display("FAIL t2_done got=%b exp=1", frame_done); end
   endtask

   task automatic test_overrun();
      int n; bit ok; beat_t got, e; int exp_ovr;
      ax = 16'sd31; ay = 16'sd32; az = 16'sd33;
      do_reset(3'b111, 1'b0, 1'b1);
      push_frame(3'b111, ax, ay, az);
      count_to_valid(4 * DIV, n);
      for (int t = 1; t <= 5; t++) begin
         repeat (DIV) step();
         exp_ovr = (t > 3) ? 3 : t;
         n_checks++;
         if (overrun_cnt !== OVR_W'(exp_ovr) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_ovr_tick%0d got=%0d busy=%b exp=%0d busy=1", t, overrun_cnt, busy, exp_ovr);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, ok, got);
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t3_beat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t3_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n; bit ok; beat_t got, e;
      ax = 16'sd11; ay = 16'sd12; az = 16'sd13;
      do_reset(3'b001, 1'b0, 1'b1);
      push_frame(3'b001, ax, ay, az);
      count_to_valid(4 * DIV, n);
      repeat (DIV - 1) step();
      out_ready = 1'b1;
      axis_mask = 3'b011;
      ax = 16'sd21; ay = 16'sd22;
      push_frame(3'b011, ax, ay, az);
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, ok, got);
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t4_beat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t4_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
         if (i == 0) begin
            n_checks++;
            if (frame_done !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1 || overrun_cnt !== '0) begin
               n_fail++;
               $display("FAIL t4_seam done=%b valid=%b busy=%b ovr=%0d exp 1 1 1 0",
                        frame_done, out_valid, busy, overrun_cnt);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int n; bit ok; beat_t got, e;
      ax = 16'sd300; ay = 16'sd301; az = 16'sd302;
      do_reset(3'b111, 1'b0, 1'b1);
      push_frame(3'b111, ax, ay, az);
      count_to_valid(4 * DIV, n);
      out_ready = 1'b1;
      wait_beat(1, ok, got);
      out_ready = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== e || out_axis !== 2'd1) begin
         n_fail++;
         $display("FAIL t5_pre ok=%0b got=%h axis_now=%0d exp=%h axis_now=1", ok, got, out_axis, e);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_data, out_axis, out_last, out_valid, frame_done, busy, overrun_cnt} !== '0) begin
         n_fail++;
         $display("FAIL t5_async_reset got=%h exp=0",
                  {out_data, out_axis, out_last, out_valid, frame_done, busy, overrun_cnt});
      end
      exp_q.delete();
      step();
      ax = 16'sd400; ay = 16'sd401; az = 16'sd402;
      out_ready = 1'b1;
      push_frame(3'b111, ax, ay, az);
      rst_n = 1'b1;
      count_to_valid(4 * DIV, n);
      n_checks++;
      if (n !== DIV) begin n_fail++; $display("FAIL t5_latency got=%0d exp=%0d", n, DIV); end
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, ok, got);
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t5_beat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t5_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
      end
   endtask

   task automatic test_enable();
      int n; bit ok; beat_t got, e;
      ax = -16'sd1; ay = 16'sd32767; az = -16'sd32768;
      do_reset(3'b111, 1'b0, 1'b1);
      push_frame(3'b111, ax, ay, az);
      count_to_valid(4 * DIV, n);
      en        = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, ok, got);
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t6_beat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t6_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
      end
      count_to_valid(3 * DIV, n);
      n_checks++;
      if (n !== 3 * DIV || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL t6_no_tick idle_cycles=%0d valid=%b exp=%0d 0", n, out_valid, 3 * DIV);
      end
      en = 1'b1;
      ax = 16'sd55; ay = 16'sd66; az = 16'sd77;
      push_frame(3'b111, ax, ay, az);
      count_to_valid(4 * DIV, n);
      n_checks++;
      if (n !== DIV) begin n_fail++; $display("FAIL t6_restart got=%0d exp=%0d", n, DIV); end
      for (int i = 0; i < 3; i++) begin
         wait_beat(1, ok, got);
         n_checks++;
         if (!ok || exp_q.size() == 0) begin
            n_fail++; $display("FAIL t6_rbeat%0d ok=%0b exp ok=1", i, ok);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL t6_rbeat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i,
                        got.data, got.axis, got.last, e.data, e.axis, e.last);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_mask_ready();
      test_overrun();
      test_back_to_back();
      test_mid_reset();
      test_enable();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before end of test");
      $fatal(1);
   end

endmodule
